// File: rtl/hazard_sched.sv
// Stall/flush scheduler for the 5-stage pipeline: merges load-use/redirect hazards with memory and mul/div waits.
// Optional performance counters (StallCyc, FlushCnt) are built when HAZ_PERF_EN is defined.
module hazard_sched #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNTW        = 8,
  parameter int PERFW       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LwHazD,
  input  logic             PCSrcE,
  input  logic             DMemReqM,
  input  logic             DMemAckM,
  input  logic             MdStartE,
  input  logic             MdDoneE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
`ifdef HAZ_PERF_EN
  output logic [PERFW-1:0] StallCyc,
  output logic [PERFW-1:0] FlushCnt,
`endif
  output logic             Busy
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MD_BUSY  = 2'd2;

  if (PERFW < 1 || MEM_TIMEOUT < 1 || MEM_TIMEOUT >= (1 << CNTW)) begin : gBadParams
    $error("hazard_sched: parameter out of range");
  end

  logic [1:0]      state, nextState;
  logic [CNTW-1:0] waitCnt, nextCnt;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, memTimeout;
  logic memAck;

  assign memAck = DMemReqM & DMemAckM;

  always_comb begin
    nextState  = state;
    nextCnt    = waitCnt;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushW     = 1'b0;
    memTimeout = 1'b0;
    case (state)
      RUN: begin
        if (DMemReqM && !DMemAckM) begin
          {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
          nextState = MEM_WAIT;
          nextCnt   = CNTW'(1);
        end else if (MdStartE) begin
          // M is not flushed here; FlushW in MD_BUSY drains the bubble next cycle.
          {stallF, stallD, stallE} = 3'b111;
          nextState = MD_BUSY;
        end else if (PCSrcE) begin
          // Branch outranks load-use so the branch in E is never bubbled.
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (LwHazD) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (memAck) begin
          nextState = RUN;
          nextCnt   = '0;
        end else if (waitCnt == CNTW'(MEM_TIMEOUT)) begin
          memTimeout = 1'b1;
          nextState  = RUN;
          nextCnt    = '0;
        end else begin
          {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
          nextCnt = waitCnt + CNTW'(1);
        end
      end
      MD_BUSY: begin
        if (MdDoneE) begin
          nextState = RUN;
        end else begin
          {stallF, stallD, stallE, flushW} = 4'b1111;
        end
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextCnt;
    end
  end

  // Outputs are forced low while reset is held, even if requests are active.
  assign StallF     = rst_n & stallF;
  assign StallD     = rst_n & stallD;
  assign StallE     = rst_n & stallE;
  assign StallM     = rst_n & stallM;
  assign FlushD     = rst_n & flushD;
  assign FlushE     = rst_n & flushE;
  assign FlushW     = rst_n & flushW;
  assign MemTimeout = rst_n & memTimeout;
  assign Busy       = rst_n & (state != RUN);

`ifdef HAZ_PERF_EN
  function automatic logic [PERFW-1:0] satInc(input logic [PERFW-1:0] v);
    return (&v) ? v : v + PERFW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCyc <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF) StallCyc <= satInc(StallCyc);
      if (FlushE) FlushCnt <= satInc(FlushCnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: expected output vectors are queued as stimulus is applied and compared mid-cycle.
module tb_hazard_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic LwHazD = 1'b0, PCSrcE = 1'b0, DMemReqM = 1'b0, DMemAckM = 1'b0;
  logic MdStartE = 1'b0, MdDoneE = 1'b0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout, Busy;
`ifdef HAZ_PERF_EN
  logic [31:0] StallCyc, FlushCnt;
`endif

  always #5 clk = ~clk;

  hazard_sched #(.MEM_TIMEOUT(4), .CNTW(8), .PERFW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .LwHazD(LwHazD), .PCSrcE(PCSrcE), .DMemReqM(DMemReqM), .DMemAckM(DMemAckM),
    .MdStartE(MdStartE), .MdDoneE(MdDoneE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout),
`ifdef HAZ_PERF_EN
    .StallCyc(StallCyc), .FlushCnt(FlushCnt),
`endif
    .Busy(Busy)
  );

  // Bit order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemTimeout,Busy}
  localparam logic [8:0] O_IDLE    = 9'b0000_000_0_0;
  localparam logic [8:0] O_LW      = 9'b1100_010_0_0;
  localparam logic [8:0] O_BR      = 9'b0000_110_0_0;
  localparam logic [8:0] O_MEMRUN  = 9'b1111_001_0_0;
  localparam logic [8:0] O_MEMWAIT = 9'b1111_001_0_1;
  localparam logic [8:0] O_RELEASE = 9'b0000_000_0_1;
  localparam logic [8:0] O_TIMEOUT = 9'b0000_000_1_1;
  localparam logic [8:0] O_MDSTART = 9'b1110_000_0_0;
  localparam logic [8:0] O_MDBUSY  = 9'b1110_001_0_1;

  typedef struct {
    logic [8:0] vec;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [8:0] obs;

  assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout, Busy};

  task automatic pushExp(input string tag, input logic [8:0] v);
    exp_t e;
    e.vec = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic checkOut();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard: observed=%b expected=<queued entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.vec) else begin
        bad++;
        $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic step(input string tag, input logic lw, input logic pc, input logic req,
                      input logic ack, input logic mds, input logic mdd, input logic [8:0] v);
    @(posedge clk);
    #1;
    LwHazD = lw; PCSrcE = pc; DMemReqM = req; DMemAckM = ack; MdStartE = mds; MdDoneE = mdd;
    pushExp(tag, v);
    @(negedge clk);
    checkOut();
  endtask

  initial begin
    // Reset held with requests active: outputs must stay low.
    LwHazD = 1'b1; DMemReqM = 1'b1; PCSrcE = 1'b1;
    #2;
    pushExp("reset_out", O_IDLE);
    checkOut();
    repeat (2) @(posedge clk);
    #1;
    pushExp("reset_hold", O_IDLE);
    checkOut();
    LwHazD = 1'b0; DMemReqM = 1'b0; PCSrcE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use
    step("lw_stall",   1, 0, 0, 0, 0, 0, O_LW);
    step("lw_after",   0, 0, 0, 0, 0, 0, O_IDLE);

    // Branch beats load-use
    step("br_vs_lw",   1, 1, 0, 0, 0, 0, O_BR);
    step("br_only",    0, 1, 0, 0, 0, 0, O_BR);
    step("br_after",   0, 0, 0, 0, 0, 0, O_IDLE);

    // Memory wait, ack after 3 stalled cycles; hazards ignored while waiting
    step("mem_c1",     0, 0, 1, 0, 0, 0, O_MEMRUN);
    step("mem_c2",     1, 1, 1, 0, 1, 0, O_MEMWAIT);
    step("mem_c3",     0, 0, 1, 0, 0, 0, O_MEMWAIT);
    step("mem_ack",    0, 0, 1, 1, 0, 0, O_RELEASE);
    step("mem_after",  0, 0, 0, 0, 0, 0, O_IDLE);

    // Single-cycle access: no stall, lower rules still apply
    step("mem_1cyc",   1, 0, 1, 1, 0, 0, O_LW);
    step("mem_1cyc_n", 0, 0, 0, 0, 0, 0, O_IDLE);

    // Timeout with MEM_TIMEOUT=4
    step("to_c1",      0, 0, 1, 0, 0, 0, O_MEMRUN);
    step("to_c2",      0, 0, 1, 0, 0, 0, O_MEMWAIT);
    step("to_c3",      0, 0, 1, 0, 0, 0, O_MEMWAIT);
    step("to_c4",      0, 0, 1, 0, 0, 0, O_MEMWAIT);
    step("to_pulse",   0, 0, 1, 0, 0, 0, O_TIMEOUT);
    step("to_run",     0, 0, 0, 0, 0, 0, O_IDLE);

    // Mul/div: start beats branch; branch ignored while busy
    step("md_start",   0, 1, 0, 0, 1, 0, O_MDSTART);
    step("md_b1",      0, 1, 0, 0, 0, 0, O_MDBUSY);
    step("md_b2",      1, 1, 0, 0, 0, 0, O_MDBUSY);
    step("md_b3",      0, 0, 0, 0, 0, 0, O_MDBUSY);
    step("md_b4",      0, 1, 0, 0, 0, 0, O_MDBUSY);
    step("md_b5",      0, 0, 0, 0, 0, 0, O_MDBUSY);
    step("md_done",    0, 1, 0, 0, 0, 1, O_RELEASE);
    step("md_after",   0, 0, 0, 0, 0, 0, O_IDLE);

    // Reset on cycle 2 of a memory wait
    step("rw_c1",      0, 0, 1, 0, 0, 0, O_MEMRUN);
    step("rw_c2",      0, 0, 1, 0, 0, 0, O_MEMWAIT);
    #1;
    rst_n = 1'b0;
    #1;
    pushExp("rw_reset", O_IDLE);
    checkOut();
    @(posedge clk);
    #1;
    pushExp("rw_reset_hold", O_IDLE);
    checkOut();
    DMemReqM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh request after reset: timeout again on the 5th cycle proves count restarted at 1
    step("rw2_c1",     0, 0, 1, 0, 0, 0, O_MEMRUN);
    step("rw2_c2",     0, 0, 1, 0, 0, 0, O_MEMWAIT);
    step("rw2_c3",     0, 0, 1, 0, 0, 0, O_MEMWAIT);
    step("rw2_c4",     0, 0, 1, 0, 0, 0, O_MEMWAIT);
    step("rw2_pulse",  0, 0, 1, 0, 0, 0, O_TIMEOUT);
    step("rw2_run",    0, 0, 0, 0, 0, 0, O_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
